// File: rtl/hat_round_ctrl.sv
// Round sequencer for the hat-catch game: launches the hat counter, paces it with a
// tick prescaler, scores catches/misses per round and handles pause and game over.
module hat_round_ctrl #(
    parameter logic [13:0] MAXCOUNT   = 14'd12348,
    parameter logic [15:0] TICK_DIV   = 16'd50000,
    parameter logic [3:0]  NUM_ROUNDS = 4'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause_btn,
    input  logic        catch,
    input  logic [13:0] count,
    output logic        cnt_go,
    output logic        cnt_en,
    output logic [7:0]  score,
    output logic [3:0]  round,
    output logic        game_over,
    output logic        paused
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        PAUSED,
        SCORE,
        OVER
    } state_t;

    localparam logic [15:0] TICK_LAST = TICK_DIV - 16'd1;

    state_t      state_reg, state_next;
    logic        start_prev_reg;
    logic        pause_prev_reg;
    logic [15:0] presc_reg, presc_next;
    logic        hit_reg, hit_next;
    logic [7:0]  score_reg, score_next;
    logic [3:0]  round_reg, round_next;

    logic start_edge;
    logic pause_edge;
    logic tick_last;

    assign start_edge = start & ~start_prev_reg;
    assign pause_edge = pause_btn & ~pause_prev_reg;
    assign tick_last  = (presc_reg == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            start_prev_reg <= 1'b0;
            pause_prev_reg <= 1'b0;
            presc_reg      <= 16'd0;
            hit_reg        <= 1'b0;
            score_reg      <= 8'd0;
            round_reg      <= 4'd0;
        end else begin
            state_reg      <= state_next;
            start_prev_reg <= start;
            pause_prev_reg <= pause_btn;
            presc_reg      <= presc_next;
            hit_reg        <= hit_next;
            score_reg      <= score_next;
            round_reg      <= round_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        hit_next   = hit_reg;
        score_next = score_reg;
        round_next = round_reg;
        unique case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    state_next = LAUNCH;
                    round_next = round_reg + 4'd1;
                end
            end
            LAUNCH: begin
                presc_next = 16'd0;
                hit_next   = 1'b0;
                state_next = RUN;
            end
            RUN: begin
                // The prescaler only advances while staying in RUN, so a pause
                // resumes from exactly the value seen when the pause edge arrived.
                if (catch) begin
                    state_next = SCORE;
                    hit_next   = 1'b1;
                end else if (count == MAXCOUNT) begin
                    state_next = SCORE;
                    hit_next   = 1'b0;
                end else if (pause_edge) begin
                    state_next = PAUSED;
                end else begin
                    presc_next = tick_last ? 16'd0 : presc_reg + 16'd1;
                end
            end
            PAUSED: begin
                if (pause_edge) begin
                    state_next = RUN;
                end
            end
            SCORE: begin
                if (hit_reg && (score_reg != 8'hFF)) begin
                    score_next = score_reg + 8'd1;
                end
                if (round_reg == NUM_ROUNDS) begin
                    state_next = OVER;
                end else begin
                    state_next = LAUNCH;
                    round_next = round_reg + 4'd1;
                end
            end
            OVER: begin
                // Clearing to 0 and entering LAUNCH collapses to round 1 directly.
                if (start_edge) begin
                    state_next = LAUNCH;
                    score_next = 8'd0;
                    round_next = 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cnt_go    = (state_reg == LAUNCH);
    assign cnt_en    = (state_reg == RUN) && tick_last;
    assign game_over = (state_reg == OVER);
    assign paused    = (state_reg == PAUSED);
    assign score     = score_reg;
    assign round     = round_reg;

endmodule

// File: tb/tb_hat_round_ctrl.sv
// Directed bench for hat_round_ctrl: expected outputs are queued as stimulus is
// driven and popped/compared once the clock edge has produced them.
module tb_hat_round_ctrl;

    localparam logic [13:0] MAXC = 14'd100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pause_btn;
    logic        catch;
    logic [13:0] count;
    logic        cnt_go;
    logic        cnt_en;
    logic [7:0]  score;
    logic [3:0]  round;
    logic        game_over;
    logic        paused;

    typedef struct {
        string      tag;
        logic       go;
        logic       en;
        logic [7:0] score;
        logic [3:0] round;
        logic       over;
        logic       paused;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    hat_round_ctrl #(
        .MAXCOUNT  (MAXC),
        .TICK_DIV  (16'd4),
        .NUM_ROUNDS(4'd2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause_btn(pause_btn),
        .catch    (catch),
        .count    (count),
        .cnt_go   (cnt_go),
        .cnt_en   (cnt_en),
        .score    (score),
        .round    (round),
        .game_over(game_over),
        .paused   (paused)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string field, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        assert (act === exp)
        else begin
            fails++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, act, exp);
        end
    endtask

    task automatic push(input string tag, input logic go, input logic en, input logic [7:0] sc,
                        input logic [3:0] rd, input logic ov, input logic pa);
        exp_t e;
        e.tag = tag; e.go = go; e.en = en; e.score = sc; e.round = rd; e.over = ov; e.paused = pa;
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cmp(e.tag, "cnt_go", {7'd0, cnt_go}, {7'd0, e.go});
            cmp(e.tag, "cnt_en", {7'd0, cnt_en}, {7'd0, e.en});
            cmp(e.tag, "score", score, e.score);
            cmp(e.tag, "round", {4'd0, round}, {4'd0, e.round});
            cmp(e.tag, "game_over", {7'd0, game_over}, {7'd0, e.over});
            cmp(e.tag, "paused", {7'd0, paused}, {7'd0, e.paused});
            $display("[TB] %s go=%0b en=%0b score=%0d round=%0d over=%0b paused=%0b",
                     e.tag, cnt_go, cnt_en, score, round, game_over, paused);
        end
    endtask

    // Drive inputs, queue the outputs expected after the next edge, then compare.
    task automatic step(input string tag, input logic st, input logic pb, input logic ca,
                        input logic [13:0] cnt, input logic go, input logic en,
                        input logic [7:0] sc, input logic [3:0] rd, input logic ov, input logic pa);
        start = st; pause_btn = pb; catch = ca; count = cnt;
        push(tag, go, en, sc, rd, ov, pa);
        @(posedge clk);
        #1;
        check_front();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause_btn = 1'b0; catch = 1'b0; count = 14'd0;
        push("reset", 0, 0, 8'd0, 4'd0, 0, 0);
        #1;
        check_front();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        step("idle", 0, 0, 0, 14'd0, 0, 0, 8'd0, 4'd0, 0, 0);
        step("launch1", 1, 0, 0, 14'd0, 1, 0, 8'd0, 4'd1, 0, 0);
        step("run_enter", 1, 0, 0, 14'd0, 0, 0, 8'd0, 4'd1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            // start edge at k=5 must be ignored mid-game
            step($sformatf("tick_k%0d", k), (k == 5), 0, 0, 14'd5 + 14'(k),
                 0, (k % 4 == 3), 8'd0, 4'd1, 0, 0);
        end

        // prescaler is 2 here; pause freezes it
        step("pause_on", 0, 1, 0, 14'd20, 0, 0, 8'd0, 4'd1, 0, 1);
        for (int k = 0; k < 100; k++) begin
            step("paused_hold", (k == 50), 0, (k == 30), MAXC, 0, 0, 8'd0, 4'd1, 0, 1);
        end
        step("pause_off", 0, 1, 0, 14'd21, 0, 0, 8'd0, 4'd1, 0, 0);
        step("resume_tick", 0, 0, 0, 14'd22, 0, 1, 8'd0, 4'd1, 0, 0);
        step("resume_wrap", 0, 0, 0, 14'd23, 0, 0, 8'd0, 4'd1, 0, 0);

        step("catch", 0, 0, 1, 14'd24, 0, 0, 8'd0, 4'd1, 0, 0);
        step("score_hit", 0, 0, 0, 14'd0, 1, 0, 8'd1, 4'd2, 0, 0);
        step("run2", 0, 0, 0, 14'd0, 0, 0, 8'd1, 4'd2, 0, 0);

        step("catch_and_max", 0, 0, 1, MAXC, 0, 0, 8'd1, 4'd2, 0, 0);
        step("over", 0, 0, 0, 14'd0, 0, 0, 8'd2, 4'd2, 1, 0);
        step("over_hold", 0, 1, 1, MAXC, 0, 0, 8'd2, 4'd2, 1, 0);
        step("over_hold2", 0, 0, 0, 14'd0, 0, 0, 8'd2, 4'd2, 1, 0);
        step("restart", 1, 0, 0, 14'd0, 1, 0, 8'd0, 4'd1, 0, 0);
        step("run_r1", 0, 0, 0, 14'd0, 0, 0, 8'd0, 4'd1, 0, 0);

        step("miss", 0, 0, 0, MAXC, 0, 0, 8'd0, 4'd1, 0, 0);
        step("score_miss", 0, 0, 0, 14'd0, 1, 0, 8'd0, 4'd2, 0, 0);
        step("run_r2", 0, 0, 0, 14'd0, 0, 0, 8'd0, 4'd2, 0, 0);
        step("r2_k1", 0, 0, 0, 14'd1, 0, 0, 8'd0, 4'd2, 0, 0);
        step("r2_k2", 0, 0, 0, 14'd2, 0, 0, 8'd0, 4'd2, 0, 0);
        step("r2_k3", 0, 0, 0, 14'd3, 0, 1, 8'd0, 4'd2, 0, 0);

        // asynchronous abort while cnt_en is high
        rst = 1'b1;
        push("async_rst", 0, 0, 8'd0, 4'd0, 0, 0);
        #1;
        check_front();
        step("rst_held", 0, 0, 0, 14'd4, 0, 0, 8'd0, 4'd0, 0, 0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step("post_rst_idle", 0, (k == 2), (k == 3), 14'd0, 0, 0, 8'd0, 4'd0, 0, 0);
        end

        // start held high through reset release yields one edge
        start = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("held_start_launch", 1, 0, 0, 14'd0, 1, 0, 8'd0, 4'd1, 0, 0);
        step("held_start_run", 1, 0, 0, 14'd0, 0, 0, 8'd0, 4'd1, 0, 0);
        step("held_start_k1", 1, 0, 0, 14'd0, 0, 0, 8'd0, 4'd1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hat_round_ctrl.md
HAT_ROUND_CTRL -- requirements
Module: hat_round_ctrl

Interface
REQ-001 Parameter MAXCOUNT, default 14'd12348: terminal value of the sequenced hat counter.
REQ-002 Parameter TICK_DIV, default 16'd50000: clock cycles per count-enable tick; legal range 1..65535.
REQ-003 Parameter NUM_ROUNDS, default 4'd8: rounds per game; legal range 1..15.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  start/restart request, level input, rising-edge detected.
REQ-007 pause_btn  in  1  pause toggle, level input, rising-edge detected.
REQ-008 catch  in  1  player caught the hat, sampled each cycle while in RUN.
REQ-009 count  in  14  current value of the hat counter.
REQ-010 cnt_go  out  1  counter restart pulse (clears the counter and puts it into its counting state).
REQ-011 cnt_en  out  1  counter increment enable.
REQ-012 score  out  8  accumulated catches.
REQ-013 round  out  4  current round number, 1-based; 0 when no game has been started.
REQ-014 game_over  out  1  high in OVER.
REQ-015 paused  out  1  high in PAUSED.

Function
REQ-016 Edge detect: start and pause_btn SHALL each be registered once; edge = current & ~previous; previous registers reset to 0, so an input held high through reset release produces one edge.
REQ-017 FSM states SHALL be IDLE, LAUNCH, RUN, PAUSED, SCORE, OVER, and the FSM SHALL leave every state only on the conditions below.
REQ-018 IDLE: a start edge SHALL go to LAUNCH.
REQ-019 LAUNCH: lasts exactly 1 cycle; cnt_go=1; round increments; tick prescaler clears to 0; next state is RUN.
REQ-020 RUN: the prescaler counts 0..TICK_DIV-1 and wraps; cnt_en=1 for exactly the one cycle in which the prescaler equals TICK_DIV-1.
REQ-021 RUN priority, highest first:
- catch=1 -> SCORE with hit.
- count==MAXCOUNT -> SCORE with miss.
- pause edge -> PAUSED.
REQ-022 PAUSED: cnt_en=0; prescaler holds its value; a pause edge returns to RUN with the prescaler resuming from the held value; catch and start are ignored.
REQ-023 SCORE: lasts exactly 1 cycle; on a hit, score increments by 1, saturating at 255; on a miss, score is unchanged. Next state is OVER if round==NUM_ROUNDS, else LAUNCH.
REQ-024 OVER: cnt_en=0; score and round hold. A start edge clears score and round to 0 and goes to LAUNCH, so the first round is reported as 1.
REQ-025 cnt_go SHALL be 1 only in LAUNCH; cnt_en SHALL be 0 in every state other than RUN, and cnt_en and cnt_go SHALL never both be 1.
REQ-026 start edges in LAUNCH, RUN, PAUSED and SCORE SHALL be ignored (no mid-game restart).
REQ-027 The catch-to-score latency SHALL be 2 cycles: catch sampled at edge N (RUN->SCORE), score updated at edge N+1.
REQ-028 The miss path SHALL go RUN -> SCORE -> LAUNCH/OVER with no count enable issued after the count==MAXCOUNT cycle.
REQ-029 All outputs SHALL be driven from registers or from decoding of the state register only, with no combinational path from any input to any output.

Reset
REQ-030 While rst=1, and immediately when it asserts, the state SHALL be IDLE and the following SHALL be 0: score, round, prescaler, edge registers, cnt_go, cnt_en, game_over, paused.
REQ-031 rst asserted mid-RUN or mid-PAUSED SHALL abort the game with no further cnt_go/cnt_en pulse until a new start edge after rst deasserts.

Verification
REQ-032 TICK_DIV=4, start edge in IDLE -> cnt_go high for 1 cycle, round=1; then cnt_en pulses every 4th cycle, first pulse 4 cycles after entering RUN.
REQ-033 In RUN, drive catch=1 for 1 cycle -> SCORE next cycle, score 0->1, then LAUNCH with cnt_go=1 and round=2.
REQ-034 count=MAXCOUNT and catch=1 in the same RUN cycle -> treated as a hit, score increments; with count=MAXCOUNT alone -> score unchanged and next round launched.
REQ-035 Pause edge with prescaler=2 -> paused=1, cnt_en stays 0 for 100 cycles; second pause edge -> first cnt_en exactly 2 cycles after RUN re-entry (prescaler resumes at 2).
REQ-036 NUM_ROUNDS=2, two hits -> game_over=1, score=2, round=2; start edge -> score=0, round=1, cnt_go pulse.
REQ-037 Assert rst for 1 cycle mid-RUN -> all outputs 0 immediately (asynchronously), state IDLE, no cnt_en until the next start edge.
